morse_sequencer: RTL
====================

MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 Parameter: DIV_W, 25, width of the unit-time divider reload value.
REQ-002 Parameter: PAT_W, 16, width of the left-justified symbol pattern.
REQ-003 Parameter: SEL_W, 3, width of the character select.
REQ-004 Parameter: GAP_UNITS, 3, number of low units inserted between repeats (>=1).
REQ-005 Port: clock  in  1  single clock, all state updates on rising edge.
REQ-006 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port: start  in  1  request to transmit, sampled each edge.
REQ-008 Port: sel  in  SEL_W  character index, sampled only on start acceptance.
REQ-009 Port: div_max  in  DIV_W  unit length minus one in clocks, sampled only on start acceptance.
REQ-010 Port: repeat_en  in  1  loop the latched character with an inter-character gap, sampled continuously.
REQ-011 Port: abort  in  1  synchronous stop, highest priority after reset.
REQ-012 Port: led  out  1  Morse output, 1 = mark.
REQ-013 Port: busy  out  1  high while not IDLE.
REQ-014 Port: done  out  1  one-cycle pulse on normal completion.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and GAP.
REQ-016 The table SHALL give a left-justified pattern and length per sel: 0 S 10101/5, 1 T 111/3, 2 U 1010111/7, 3 V 101010111/9, 4 W 101110111/9, 5 X 11101010111/11, 6 Y 1110101110111/13, 7 Z 11101110101/11.
REQ-017 A tick SHALL occur on an edge where the divider equals 0; the divider SHALL then reload div_max, otherwise decrement.
REQ-018 On start in IDLE, the same edge SHALL set led to the pattern MSB, latch the pattern shifted left by 1, set remaining count to len-1, load the divider with div_max and enter SHIFT.
REQ-019 In SHIFT, on a tick with count>0, led SHALL take the next MSB, the pattern SHALL shift left and count SHALL decrement.
REQ-020 In SHIFT, on a tick with count=0 and repeat_en=0, led SHALL go 0, done SHALL pulse for one cycle and the FSM SHALL enter IDLE.
REQ-021 In SHIFT, on a tick with count=0 and repeat_en=1, led SHALL go 0 and the FSM SHALL enter GAP with the gap count set to GAP_UNITS-1.
REQ-022 In GAP, led SHALL stay 0; on the final tick the FSM SHALL reload the latched original pattern (not sel) and behave as in REQ-018 without re-sampling div_max.
REQ-023 Each bit SHALL therefore last exactly div_max+1 clocks, including div_max=0 (one clock per bit).
REQ-024 A table length of 0 SHALL cause done to pulse on the accepting edge with the FSM remaining in IDLE.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort SHALL, on the next edge in any state, force IDLE with led=0 and busy=0 and no done pulse; abort SHALL take priority over simultaneous start.
REQ-027 busy SHALL be a registered output, high in SHIFT and GAP.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, led=0, busy=0, done=0, divider=0, pattern=0 and count=0, including mid-transmission.

Structure
REQ-029 State encoding, the table constants and the length-field width function SHALL live in shared package morse_pkg.
REQ-030 The table SHALL be a combinational sub-module morse_table (sel -> pattern, len); the divider, shifter and FSM SHALL be in morse_sequencer.

Verification
REQ-031 Scenario: div_max=3, sel=1, start one cycle -> led high for 12 clocks from the accepting edge, then done for 1 clock, busy low.
REQ-032 Scenario: div_max=0, sel=0 -> led sequence 1,0,1,0,1 on consecutive clocks, done on clock 5.
REQ-033 Scenario: div_max=1, sel=1, repeat_en=1 -> led high for 6 clocks, low for 6 (GAP_UNITS=3), high for 6, repeating with no done.
REQ-034 Scenario: start during transmission with different sel -> output unchanged, exactly one done.
REQ-035 Scenario: abort asserted with start during SHIFT -> next edge led=0, busy=0, no done, new start then accepted normally.
REQ-036 Scenario: reset_n pulsed low mid-bit, asynchronous to clock -> outputs 0 without waiting for an edge, and a clean restart follows.

Source files
------------

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse sequencer:
//   - FSM state encoding (IDLE / SHIFT / GAP)
//   - symbol table constants, stored right-justified with their lengths
//   - len_width(): width of the length field needed for a given pattern width
// No ports; imported by morse_table and morse_sequencer.
// -----------------------------------------------------------------------------
package morse_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Storage width of the raw symbol constants (longest symbol is 13 units)
  localparam int SYM_W   = 16;
  localparam int NUM_SYM = 8;

  // Bits needed to hold a length in the range 0..pat_w
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Right-justified unit patterns (1 = mark). Dot = 1, dash = 111, and a
  // single 0 separates elements inside one character.
  function automatic logic [SYM_W-1:0] sym_bits(input int idx);
    case (idx)
      0:       return 16'h0015; // S 10101
      1:       return 16'h0007; // T 111
      2:       return 16'h0057; // U 1010111
      3:       return 16'h0157; // V 101010111
      4:       return 16'h0177; // W 101110111
      5:       return 16'h0757; // X 11101010111
      6:       return 16'h1D77; // Y 1110101110111
      7:       return 16'h0775; // Z 11101110101
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int sym_len(input int idx);
    case (idx)
      0:       return 5;
      1:       return 3;
      2:       return 7;
      3:       return 9;
      4:       return 9;
      5:       return 11;
      6:       return 13;
      7:       return 11;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/morse_table.sv
// -----------------------------------------------------------------------------
// morse_table
// Combinational character lookup. Produces the unit pattern left-justified in
// PAT_W bits (first unit in the MSB) and its length in units.
// Ports:
//   sel     in  SEL_W  character index
//   pattern out PAT_W  left-justified unit pattern
//   len     out LEN_W  pattern length in units (0 = nothing to send)
// -----------------------------------------------------------------------------
module morse_table
  import morse_pkg::*;
#(
  parameter int PAT_W = 16,
  parameter int SEL_W = 3,
  parameter int LEN_W = len_width(PAT_W)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [PAT_W-1:0] pattern,
  output logic [LEN_W-1:0] len
);

  logic [SYM_W-1:0] raw;
  int               n;

  always_comb begin
    raw     = sym_bits(int'(sel));
    n       = sym_len(int'(sel));
    pattern = '0;
    len     = '0;
    // A symbol that does not fit the configured pattern width is reported as
    // length 0 so the sequencer never sends a truncated character.
    if ((n > 0) && (n <= PAT_W) && (n <= SYM_W)) begin
      len     = LEN_W'(n);
      pattern = PAT_W'(raw) << (PAT_W - n);
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// -----------------------------------------------------------------------------
// morse_sequencer
// Sends one Morse character on led, one pattern unit per divider period of
// div_max+1 clocks, optionally looping with a GAP_UNITS-long low gap.
// Ports:
//   clock      in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      transmit request
//   sel        in   SEL_W  character index, captured when start is accepted
//   div_max    in   DIV_W  unit length minus one, captured when start accepted
//   repeat_en  in   1      loop the latched character (sampled continuously)
//   abort      in   1      synchronous stop, wins over start
//   led        out  1      Morse output, 1 = mark
//   busy       out  1      registered, high in SHIFT and GAP
//   done       out  1      one-cycle pulse on normal completion
//   state_dbg  out  2      current FSM state (morse_pkg ST_* encoding)
//
// Handshake: start is a level request with no ready signal. It is accepted on
// any rising edge where the FSM is IDLE and abort is low; at every other edge
// it is ignored, so a request held across a transmission is not queued.
// -----------------------------------------------------------------------------
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int DIV_W     = 25,
  parameter int PAT_W     = 16,
  parameter int SEL_W     = 3,
  parameter int GAP_UNITS = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [SEL_W-1:0] sel,
  input  logic [DIV_W-1:0] div_max,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int LEN_W = len_width(PAT_W);
  localparam int GAP_W = $clog2(GAP_UNITS + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_UNITS - 1);

  logic [1:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_rld;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] pat_orig;
  logic [LEN_W-1:0] len_orig;
  logic [LEN_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic [PAT_W-1:0] tbl_pat;
  logic [LEN_W-1:0] tbl_len;
  logic             tick;

  morse_table #(
    .PAT_W (PAT_W),
    .SEL_W (SEL_W),
    .LEN_W (LEN_W)
  ) u_table (
    .sel     (sel),
    .pattern (tbl_pat),
    .len     (tbl_len)
  );

  // A unit boundary happens on the edge where the divider has run down to 0.
  assign tick      = (div_cnt == '0);
  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      div_rld  <= '0;
      pat_q    <= '0;
      pat_orig <= '0;
      len_orig <= '0;
      cnt      <= '0;
      gap_cnt  <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= ST_IDLE;
        div_cnt <= '0;
        cnt     <= '0;
        gap_cnt <= '0;
        led     <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (tbl_len == '0) begin
                // Empty character: complete immediately without leaving IDLE.
                done <= 1'b1;
              end else begin
                led      <= tbl_pat[PAT_W-1];
                pat_q    <= tbl_pat << 1;
                pat_orig <= tbl_pat;
                len_orig <= tbl_len;
                cnt      <= tbl_len - LEN_W'(1);
                div_cnt  <= div_max;
                div_rld  <= div_max;
                busy     <= 1'b1;
                state    <= ST_SHIFT;
              end
            end
          end

          ST_SHIFT: begin
            if (tick) begin
              div_cnt <= div_rld;
              if (cnt != '0) begin
                led   <= pat_q[PAT_W-1];
                pat_q <= pat_q << 1;
                cnt   <= cnt - LEN_W'(1);
              end else begin
                led <= 1'b0;
                if (repeat_en) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= ST_GAP;
                end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end
              end
            end else begin
              div_cnt <= div_cnt - DIV_W'(1);
            end
          end

          ST_GAP: begin
            if (tick) begin
              div_cnt <= div_rld;
              if (gap_cnt == '0) begin
                // Replay the character captured at start; sel and div_max
                // may have changed since and are deliberately not looked at.
                led   <= pat_orig[PAT_W-1];
                pat_q <= pat_orig << 1;
                cnt   <= len_orig - LEN_W'(1);
                state <= ST_SHIFT;
              end else begin
                gap_cnt <= gap_cnt - GAP_W'(1);
              end
            end else begin
              div_cnt <= div_cnt - DIV_W'(1);
            end
          end

          default: begin
            state <= ST_IDLE;
            led   <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
